// File: rtl/pipe_ctrl.sv
// Pipeline control for the 16-bit core: sequences PC, IF/ID and ID/EX for
// jump flushes, load-use bubbles and multi-cycle EX holds with a watchdog.
module pipe_ctrl #(
  parameter int ADDR_W     = 7,
  parameter int REG_AW     = 3,
  parameter int LOAD_STALL = 1,
  parameter int MC_MAX     = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              jump_req_i,
  input  logic [ADDR_W-1:0] jump_addr_i,
  input  logic [REG_AW-1:0] id_rs1_i,
  input  logic [REG_AW-1:0] id_rs2_i,
  input  logic              id_rs1_used_i,
  input  logic              id_rs2_used_i,
  input  logic [REG_AW-1:0] ex_rd_i,
  input  logic              ex_reg_wen_i,
  input  logic              ex_is_load_i,
  input  logic              mc_start_i,
  input  logic              mc_done_i,
  output logic              jump_en_o,
  output logic [ADDR_W-1:0] jump_addr_o,
  output logic              stall_pc_o,
  output logic              stall_if_id_o,
  output logic              bubble_id_ex_o,
  output logic              hold_ex_o,
  output logic              mc_err_o,
  output logic [1:0]        state_o
);

  typedef enum logic [1:0] {
    RUN       = 2'd0,
    LOAD_WAIT = 2'd1,
    MC_BUSY   = 2'd2
  } state_e;

  localparam logic [7:0] LS_M1  = 8'(LOAD_STALL - 1);
  localparam logic [7:0] MC_LIM = 8'(MC_MAX);

  state_e     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic       err_q, err_d;

  logic jump_en, stall, bubble, hold;
  logic hazard;

  // Register 0 is an ordinary register here, so no zero-index exclusion.
  assign hazard = ex_is_load_i & ex_reg_wen_i &
                  ((id_rs1_used_i & (id_rs1_i == ex_rd_i)) |
                   (id_rs2_used_i & (id_rs2_i == ex_rd_i)));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RUN;
      cnt_q   <= 8'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    jump_en = 1'b0;
    stall   = 1'b0;
    bubble  = 1'b0;
    hold    = 1'b0;
    case (state_q)
      RUN: begin
        if (jump_req_i) begin
          jump_en = 1'b1;
        end else if (mc_start_i) begin
          stall   = 1'b1;
          hold    = 1'b1;
          cnt_d   = 8'd1;
          state_d = MC_BUSY;
        end else if (hazard) begin
          stall  = 1'b1;
          bubble = 1'b1;
          if (LOAD_STALL > 1) begin
            cnt_d   = LS_M1;
            state_d = LOAD_WAIT;
          end
        end
      end
      LOAD_WAIT: begin
        if (jump_req_i) begin
          jump_en = 1'b1;
          cnt_d   = 8'd0;
          state_d = RUN;
        end else begin
          stall  = 1'b1;
          bubble = 1'b1;
          cnt_d  = cnt_q - 8'd1;
          if (cnt_q == 8'd1) state_d = RUN;
        end
      end
      MC_BUSY: begin
        // Done wins over timeout so a result arriving on the last cycle is kept.
        if (mc_done_i) begin
          cnt_d   = 8'd0;
          state_d = RUN;
        end else if (cnt_q == MC_LIM) begin
          err_d   = 1'b1;
          cnt_d   = 8'd0;
          state_d = RUN;
        end else begin
          stall = 1'b1;
          hold  = 1'b1;
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: begin
        state_d = RUN;
        cnt_d   = 8'd0;
      end
    endcase
  end

  assign jump_en_o      = jump_en & ~rst;
  assign jump_addr_o    = jump_en_o ? jump_addr_i : '0;
  assign stall_pc_o     = stall & ~rst;
  assign stall_if_id_o  = stall & ~rst;
  assign bubble_id_ex_o = bubble & ~rst;
  assign hold_ex_o      = hold & ~rst;
  assign mc_err_o       = err_q;
  assign state_o        = state_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Bench for pipe_ctrl: two instances (LOAD_STALL=1 and 3) share stimulus and
// are checked against a cycle-level behavioural model, a vector table and hand sequences.
module tb_pipe_ctrl;
  localparam int MCM = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic       jump_req;
  logic [6:0] jump_addr;
  logic [2:0] rs1, rs2, rd;
  logic       u1, u2, wen, is_load, mc_start, mc_done;

  logic       a_jen, a_spc, a_sif, a_bub, a_hold, a_err;
  logic [6:0] a_jaddr;
  logic [1:0] a_st;
  logic       b_jen, b_spc, b_sif, b_bub, b_hold, b_err;
  logic [6:0] b_jaddr;
  logic [1:0] b_st;

  pipe_ctrl #(.ADDR_W(7), .REG_AW(3), .LOAD_STALL(1), .MC_MAX(MCM)) u_dut1 (
    .clk(clk), .rst(rst), .jump_req_i(jump_req), .jump_addr_i(jump_addr),
    .id_rs1_i(rs1), .id_rs2_i(rs2), .id_rs1_used_i(u1), .id_rs2_used_i(u2),
    .ex_rd_i(rd), .ex_reg_wen_i(wen), .ex_is_load_i(is_load),
    .mc_start_i(mc_start), .mc_done_i(mc_done),
    .jump_en_o(a_jen), .jump_addr_o(a_jaddr), .stall_pc_o(a_spc),
    .stall_if_id_o(a_sif), .bubble_id_ex_o(a_bub), .hold_ex_o(a_hold),
    .mc_err_o(a_err), .state_o(a_st)
  );

  pipe_ctrl #(.ADDR_W(7), .REG_AW(3), .LOAD_STALL(3), .MC_MAX(MCM)) u_dut3 (
    .clk(clk), .rst(rst), .jump_req_i(jump_req), .jump_addr_i(jump_addr),
    .id_rs1_i(rs1), .id_rs2_i(rs2), .id_rs1_used_i(u1), .id_rs2_used_i(u2),
    .ex_rd_i(rd), .ex_reg_wen_i(wen), .ex_is_load_i(is_load),
    .mc_start_i(mc_start), .mc_done_i(mc_done),
    .jump_en_o(b_jen), .jump_addr_o(b_jaddr), .stall_pc_o(b_spc),
    .stall_if_id_o(b_sif), .bubble_id_ex_o(b_bub), .hold_ex_o(b_hold),
    .mc_err_o(b_err), .state_o(b_st)
  );

  logic [14:0] p1, p3;
  assign p1 = {a_jen, a_jaddr, a_spc, a_sif, a_bub, a_hold, a_err, a_st};
  assign p3 = {b_jen, b_jaddr, b_spc, b_sif, b_bub, b_hold, b_err, b_st};

  function automatic logic [14:0] pk(logic j, logic [6:0] a, logic s, logic f,
                                     logic b, logic h, logic e, logic [1:0] st);
    return {j, a, s, f, b, h, e, st};
  endfunction

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: remaining bubbles, age of the multi-cycle op, sticky error.
  int ld_left[2];
  int mc_age[2];
  bit merr[2];
  int ls_of[2] = '{1, 3};

  function automatic bit hz();
    return is_load && wen && ((u1 && rs1 == rd) || (u2 && rs2 == rd));
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      ld_left[i] = 0;
      mc_age[i]  = 0;
      merr[i]    = 1'b0;
    end
  endtask

  task automatic model_eval(int i, output logic [14:0] e);
    logic jen, sp, bb, hd, eb;
    logic [1:0] st;
    jen = 1'b0; sp = 1'b0; bb = 1'b0; hd = 1'b0;
    eb = merr[i];
    st = (mc_age[i] > 0) ? 2'd2 : (ld_left[i] > 0) ? 2'd1 : 2'd0;
    if (mc_age[i] > 0) begin
      if (mc_done) mc_age[i] = 0;
      else if (mc_age[i] == MCM) begin
        merr[i] = 1'b1;
        mc_age[i] = 0;
      end else begin
        sp = 1'b1; hd = 1'b1;
        mc_age[i]++;
      end
    end else if (ld_left[i] > 0) begin
      if (jump_req) begin
        jen = 1'b1;
        ld_left[i] = 0;
      end else begin
        sp = 1'b1; bb = 1'b1;
        ld_left[i]--;
      end
    end else if (jump_req) begin
      jen = 1'b1;
    end else if (mc_start) begin
      sp = 1'b1; hd = 1'b1;
      mc_age[i] = 1;
    end else if (hz()) begin
      sp = 1'b1; bb = 1'b1;
      ld_left[i] = ls_of[i] - 1;
    end
    e = pk(jen, jen ? jump_addr : 7'd0, sp, sp, bb, hd, eb, st);
  endtask

  task automatic idle();
    jump_req = 0; jump_addr = 0; rs1 = 0; rs2 = 0; rd = 0;
    u1 = 0; u2 = 0; wen = 0; is_load = 0; mc_start = 0; mc_done = 0;
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  task automatic advance();
    logic [14:0] e0, e1;
    model_eval(0, e0);
    model_eval(1, e1);
    chk("model_ls1", 32'(p1), 32'(e0));
    chk("model_ls3", 32'(p3), 32'(e1));
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle();
    #1;
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic set_hazard();
    idle();
    is_load = 1; wen = 1; rd = 3'd3; rs2 = 3'd3; u2 = 1;
  endtask

  typedef struct {
    logic       j;
    logic [6:0] a;
    logic [2:0] r1, r2;
    logic       v1, v2;
    logic [2:0] d;
    logic       w, ld, s, dn;
    logic [14:0] exp;
  } vec_t;

  function automatic vec_t mkv(logic j, logic [6:0] a, logic [2:0] r1, logic [2:0] r2,
                               logic v1, logic v2, logic [2:0] d, logic w, logic ld,
                               logic s, logic dn, logic [14:0] exp);
    vec_t v;
    v.j = j; v.a = a; v.r1 = r1; v.r2 = r2; v.v1 = v1; v.v2 = v2; v.d = d;
    v.w = w; v.ld = ld; v.s = s; v.dn = dn; v.exp = exp;
    return v;
  endfunction

  vec_t tbl[11];

  initial begin
    logic [14:0] zero, bub0;
    zero = pk(0, 0, 0, 0, 0, 0, 0, 0);
    bub0 = pk(0, 0, 1, 1, 1, 0, 0, 0);
    tbl[0]  = mkv(0, 7'h00, 0, 0, 0, 0, 0, 0, 0, 0, 0, zero);
    tbl[1]  = mkv(0, 7'h00, 1, 3, 0, 1, 3, 1, 1, 0, 0, bub0);
    tbl[2]  = mkv(0, 7'h00, 0, 0, 0, 0, 0, 0, 0, 0, 0, zero);
    tbl[3]  = mkv(0, 7'h00, 5, 3, 1, 0, 3, 1, 1, 0, 0, zero);
    tbl[4]  = mkv(0, 7'h00, 3, 0, 1, 0, 3, 0, 1, 0, 0, zero);
    tbl[5]  = mkv(0, 7'h00, 0, 6, 1, 0, 0, 1, 1, 0, 0, bub0);
    tbl[6]  = mkv(1, 7'h2A, 3, 3, 1, 1, 3, 1, 1, 1, 0, pk(1, 7'h2A, 0, 0, 0, 0, 0, 0));
    tbl[7]  = mkv(0, 7'h00, 0, 0, 0, 0, 0, 0, 0, 0, 0, zero);
    tbl[8]  = mkv(1, 7'h55, 0, 0, 0, 0, 0, 0, 0, 0, 0, pk(1, 7'h55, 0, 0, 0, 0, 0, 0));
    tbl[9]  = mkv(0, 7'h00, 2, 2, 1, 1, 4, 1, 1, 0, 0, zero);
    tbl[10] = mkv(0, 7'h00, 3, 3, 1, 1, 3, 1, 0, 0, 0, zero);

    // Reset state, observed while rst is still high.
    rst = 1'b1;
    idle();
    model_reset();
    #1;
    chk("reset_ls1", 32'(p1), 32'(zero));
    chk("reset_ls3", 32'(p3), 32'(zero));
    @(posedge clk);
    #1;
    rst = 1'b0;

    for (int i = 0; i < 11; i++) begin
      jump_req = tbl[i].j; jump_addr = tbl[i].a; rs1 = tbl[i].r1; rs2 = tbl[i].r2;
      u1 = tbl[i].v1; u2 = tbl[i].v2; rd = tbl[i].d; wen = tbl[i].w;
      is_load = tbl[i].ld; mc_start = tbl[i].s; mc_done = tbl[i].dn;
      settle();
      chk($sformatf("tbl%0d", i), 32'(p1), 32'(tbl[i].exp));
      advance();
    end

    // Three-bubble load-use wait, then the same wait aborted by a jump.
    do_reset();
    set_hazard();
    settle(); chk("ls3_c0", 32'(p3), 32'(pk(0, 0, 1, 1, 1, 0, 0, 0))); advance();
    idle();
    settle(); chk("ls3_c1", 32'(p3), 32'(pk(0, 0, 1, 1, 1, 0, 0, 1))); advance();
    settle(); chk("ls3_c2", 32'(p3), 32'(pk(0, 0, 1, 1, 1, 0, 0, 1))); advance();
    settle(); chk("ls3_c3", 32'(p3), 32'(zero)); advance();
    set_hazard();
    settle(); advance();
    idle();
    jump_req = 1; jump_addr = 7'h11;
    settle(); chk("ls3_abort", 32'(p3), 32'(pk(1, 7'h11, 0, 0, 0, 0, 0, 1))); advance();
    idle();
    settle(); chk("ls3_after", 32'(p3), 32'(zero)); advance();

    // Multi-cycle op with done four cycles after start.
    mc_start = 1;
    settle(); chk("mc_start", 32'(a_hold), 32'd1); advance();
    mc_start = 0;
    for (int k = 1; k < 4; k++) begin
      settle(); chk($sformatf("mc_hold%0d", k), 32'({a_hold, a_st}), 32'({1'b1, 2'd2}));
      advance();
    end
    mc_done = 1;
    settle(); chk("mc_done", 32'(p1), 32'(pk(0, 0, 0, 0, 0, 0, 0, 2))); advance();
    mc_done = 0;
    settle(); chk("mc_after", 32'(p1), 32'(zero)); advance();

    // Watchdog: no done, stall for exactly MC_MAX cycles then sticky error.
    mc_start = 1;
    settle(); chk("wd_start", 32'(a_hold), 32'd1); advance();
    mc_start = 0;
    for (int k = 1; k < MCM; k++) begin
      settle(); chk($sformatf("wd_hold%0d", k), 32'(a_hold), 32'd1); advance();
    end
    settle(); chk("wd_expire", 32'(p1), 32'(pk(0, 0, 0, 0, 0, 0, 0, 2))); advance();
    settle(); chk("wd_err", 32'(p1), 32'(pk(0, 0, 0, 0, 0, 0, 1, 0))); advance();
    mc_start = 1;
    settle(); chk("wd2_start", 32'({a_hold, a_err}), 32'(2'b11)); advance();
    mc_start = 0;
    settle(); chk("wd2_hold", 32'({a_hold, a_err}), 32'(2'b11)); advance();
    mc_done = 1;
    settle(); chk("wd2_done", 32'(p1), 32'(pk(0, 0, 0, 0, 0, 0, 1, 2))); advance();
    mc_done = 0;
    settle(); chk("wd2_after", 32'(p1), 32'(pk(0, 0, 0, 0, 0, 0, 1, 0))); advance();

    // Asynchronous reset in the middle of MC_BUSY.
    mc_start = 1;
    settle(); advance();
    mc_start = 0;
    settle(); advance();
    mc_start = 1;
    rst = 1'b1;
    #1;
    chk("rst_async_ls1", 32'(p1), 32'(zero));
    chk("rst_async_ls3", 32'(p3), 32'(zero));
    @(posedge clk);
    #1;
    chk("rst_hold", 32'(p1), 32'(zero));
    idle();
    model_reset();
    rst = 1'b0;

    // Randomised traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      jump_req  = ($urandom % 8) == 0;
      jump_addr = 7'($urandom);
      rs1 = 3'($urandom % 4); rs2 = 3'($urandom % 4); rd = 3'($urandom % 4);
      u1 = 1'($urandom % 2); u2 = 1'($urandom % 2);
      wen = ($urandom % 4) != 0;
      is_load = 1'($urandom % 2);
      mc_start = ($urandom % 10) == 0;
      mc_done  = ($urandom % 8) == 0;
      settle();
      advance();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
- Pipeline control unit for the 16-bit, 7-bit-PC core.
- Sequences the IF/ID and ID/EX pipeline registers and the PC.
- Generates jump flush (jump_en to the ID/EX register), load-use stall/bubble and multi-cycle-EX hold, with a watchdog on multi-cycle operations.
- Sits beside the pipeline and sees the ID-stage operands and the EX-stage destination, load and jump info.

Parameters:
- ADDR_W, 7, instruction address width.
- REG_AW, 3, register address width.
- LOAD_STALL, 1, bubbles inserted per load-use hazard; legal range 1..3.
- MC_MAX, 16, watchdog limit in cycles for a multi-cycle EX operation; legal range 2..255.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous reset, active-high.
- jump_req_i  in  1  EX-stage branch/jump taken.
- jump_addr_i  in  ADDR_W  EX-stage jump target.
- id_rs1_i  in  REG_AW  ID-stage source register 1.
- id_rs2_i  in  REG_AW  ID-stage source register 2.
- id_rs1_used_i  in  1  ID-stage instruction reads rs1.
- id_rs2_used_i  in  1  ID-stage instruction reads rs2.
- ex_rd_i  in  REG_AW  EX-stage destination register.
- ex_reg_wen_i  in  1  EX-stage instruction writes rd.
- ex_is_load_i  in  1  EX-stage instruction is a load.
- mc_start_i  in  1  EX-stage instruction is a multi-cycle op; 1-cycle pulse.
- mc_done_i  in  1  multi-cycle unit result valid.
- jump_en_o  out  1  flush IF/ID and ID/EX (ID/EX loads NOP and zeros), load PC.
- jump_addr_o  out  ADDR_W  PC load value.
- stall_pc_o  out  1  PC holds.
- stall_if_id_o  out  1  IF/ID register holds.
- bubble_id_ex_o  out  1  ID/EX loads NOP and zeros.
- hold_ex_o  out  1  ID/EX register and EX holds.
- mc_err_o  out  1  sticky watchdog timeout flag.
- state_o  out  2  current FSM state, for debug.

Behaviour:
- State encoding: RUN=0, LOAD_WAIT=1, MC_BUSY=2. Registers: state, cnt (8 bit), mc_err.
- Reset (async, any time including mid-operation): state=RUN, cnt=0, mc_err=0.
- All control outputs are combinational from state and inputs, and are forced 0 while rst=1.
- jump_addr_o = jump_addr_i whenever jump_en_o=1, else 0.
- hazard = ex_is_load_i & ex_reg_wen_i & ((id_rs1_used_i & id_rs1_i==ex_rd_i) | (id_rs2_used_i & id_rs2_i==ex_rd_i)). Register 0 is not special.
- RUN, priority jump > mc_start > hazard:
  - jump_req_i: jump_en_o=1, no stall; stay RUN. mc_start_i and hazard in the same cycle are ignored.
  - mc_start_i: stall_pc_o=stall_if_id_o=hold_ex_o=1; cnt<=1; next MC_BUSY.
  - hazard: stall_pc_o=stall_if_id_o=bubble_id_ex_o=1. If LOAD_STALL==1 stay RUN; else cnt<=LOAD_STALL-1 and next LOAD_WAIT.
  - otherwise: all outputs 0.
- LOAD_WAIT:
  - stall_pc_o=stall_if_id_o=bubble_id_ex_o=1; cnt<=cnt-1.
  - When cnt==1, next RUN.
  - jump_req_i aborts the wait: jump_en_o=1, stalls 0, next RUN, cnt<=0.
- MC_BUSY:
  - mc_done_i=1: all outputs 0 this cycle so the result advances; next RUN, cnt<=0.
  - Else if cnt==MC_MAX: stalls 0, mc_err<=1, next RUN, cnt<=0.
  - Else: stall_pc_o=stall_if_id_o=hold_ex_o=1; cnt<=cnt+1.
  - jump_req_i and mc_start_i are ignored in this state (protocol violation; no output effect).
- mc_err is cleared only by rst.
- Total stall for a multi-cycle op completing with done k cycles after start (k>=1) is k cycles. Timeout stalls exactly MC_MAX cycles.
- bubble_id_ex_o and hold_ex_o are never both 1. jump_en_o is never asserted together with any stall.

Test Plan:
- Reset then idle inputs -> all outputs 0, state_o=0; assert rst mid-MC_BUSY -> state_o=0 and stalls 0 immediately, without waiting for a clock edge.
- EX load writes rd=3, ID reads rs2=3 (used), LOAD_STALL=1 -> exactly 1 cycle of stall_pc/stall_if_id/bubble, then 0; with rs2_used_i=0 -> no stall.
- LOAD_STALL=3, hazard -> 3 consecutive bubble cycles (RUN, LOAD_WAIT, LOAD_WAIT) then RUN; jump_req_i in the 2nd cycle -> jump_en_o=1, stalls 0, RUN next.
- jump_req_i=1, jump_addr_i=7'h2A, with hazard and mc_start_i both true -> jump_en_o=1, jump_addr_o=7'h2A, no stall; state stays RUN.
- mc_start_i, then mc_done_i 4 cycles later, MC_MAX=16 -> hold_ex_o high for exactly 4 cycles, 0 in the done cycle, mc_err_o=0.
- mc_start_i, no done, MC_MAX=16 -> hold for 16 cycles, then mc_err_o=1 sticky and state_o=0; a later mc_start_i/done works normally with mc_err_o still 1.
